// File: rtl/packet_handler_hls_deadlock_report_unit.sv
// Deadlock confirmation and reporting: launches a token from the lowest flagged process,
// gathers the set of processes it visits, then reports that set one index at a time.
// Optional trace timeout: define PACKET_HANDLER_DL_TIMEOUT_EN.
module packet_handler_hls_deadlock_report_unit #(
  parameter int unsigned PROC_NUM = 4,
  parameter int unsigned IDX_W    = 2,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_in_vec,
  input  logic [PROC_NUM-1:0] token_in_vec,
  output logic [PROC_NUM-1:0] origin,
  output logic                token_clear,
  output logic                dl_flag,
  output logic [PROC_NUM-1:0] cycle_vec,
  output logic                report_valid,
  output logic [IDX_W-1:0]    report_proc,
  input  logic                report_ready
);

  if (IDX_W == 0 || IDX_W < $clog2(PROC_NUM) || TIMEOUT == 0) begin : g_param_check
    $error("packet_handler_hls_deadlock_report_unit: invalid PROC_NUM/IDX_W/TIMEOUT");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ORIGIN,
    ST_TRACE,
    ST_REPORT,
    ST_DONE
  } state_t;

  localparam logic [PROC_NUM-1:0] ONE = PROC_NUM'(1);

  function automatic logic [IDX_W-1:0] lowest_set(input logic [PROC_NUM-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int unsigned i = PROC_NUM; i > 0; i--) begin
      if (v[i-1]) r = IDX_W'(i - 1);
    end
    return r;
  endfunction

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q;
  logic [PROC_NUM-1:0] pending_q;
  logic [PROC_NUM-1:0] idx_oh;
  logic [PROC_NUM-1:0] trace_set;
  logic [PROC_NUM-1:0] pending_after;
  logic [IDX_W-1:0]    report_head;
  logic                token_hit;
  logic                timeout_hit;

  assign idx_oh        = ONE << idx_q;
  assign token_hit     = |(token_in_vec & idx_oh);
  assign trace_set     = cycle_vec | token_in_vec;
  assign report_head   = lowest_set(pending_q);
  assign pending_after = pending_q & ~(ONE << report_head);
  assign report_proc   = report_head;

`ifdef PACKET_HANDLER_DL_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] tmo_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_ORIGIN) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_TRACE) begin
      tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
    end
  end

  assign timeout_hit = (tmo_cnt_q == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A returning token takes priority over an expiring timeout.
  always_comb begin
    state_d      = state_q;
    origin       = '0;
    token_clear  = 1'b0;
    report_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|dl_in_vec) state_d = ST_ORIGIN;
      end
      ST_ORIGIN: begin
        origin  = idx_oh;
        state_d = ST_TRACE;
      end
      ST_TRACE: begin
        if (token_hit) begin
          token_clear = 1'b1;
          state_d     = ST_REPORT;
        end else if (timeout_hit) begin
          token_clear = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_REPORT: begin
        report_valid = 1'b1;
        if (report_ready && (pending_after == '0)) state_d = ST_DONE;
      end
      ST_DONE: begin
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // cycle_vec keeps the full set; pending_q is the copy consumed by reporting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q     <= '0;
      pending_q <= '0;
      cycle_vec <= '0;
      dl_flag   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|dl_in_vec) idx_q <= lowest_set(dl_in_vec);
        end
        ST_ORIGIN: begin
          cycle_vec <= idx_oh;
        end
        ST_TRACE: begin
          if (token_hit) begin
            cycle_vec <= trace_set;
            pending_q <= trace_set;
            dl_flag   <= 1'b1;
          end else if (timeout_hit) begin
            cycle_vec <= '0;
          end else begin
            cycle_vec <= trace_set;
          end
        end
        ST_REPORT: begin
          if (report_ready) pending_q <= pending_after;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_packet_handler_hls_deadlock_report_unit.sv
// Self-checking bench for packet_handler_hls_deadlock_report_unit (PROC_NUM=4, IDX_W=2, TIMEOUT=8).
module tb_packet_handler_hls_deadlock_report_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] dl_in_vec;
  logic [3:0] token_in_vec;
  logic [3:0] origin;
  logic       token_clear;
  logic       dl_flag;
  logic [3:0] cycle_vec;
  logic       report_valid;
  logic [1:0] report_proc;
  logic       report_ready;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  packet_handler_hls_deadlock_report_unit #(
    .PROC_NUM(4),
    .IDX_W(2),
    .TIMEOUT(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .dl_in_vec(dl_in_vec),
    .token_in_vec(token_in_vec),
    .origin(origin),
    .token_clear(token_clear),
    .dl_flag(dl_flag),
    .cycle_vec(cycle_vec),
    .report_valid(report_valid),
    .report_proc(report_proc),
    .report_ready(report_ready)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // Inputs change 1ns after the rising edge; outputs are sampled 4ns after it.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  function automatic int lowest_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic do_reset();
    reset        = 1'b1;
    dl_in_vec    = '0;
    token_in_vec = '0;
    report_ready = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    dl_in_vec    = '0;
    token_in_vec = '0;
    report_ready = 1'b0;
    settle();
    n_cmp++; if (origin !== 4'b0000) begin n_err++; $display("FAIL reset_origin: got %b expected 0000", origin); end
    n_cmp++; if (token_clear !== 1'b0) begin n_err++; $display("FAIL reset_token_clear: got %b expected 0", token_clear); end
    n_cmp++; if (dl_flag !== 1'b0) begin n_err++; $display("FAIL reset_dl_flag: got %b expected 0", dl_flag); end
    n_cmp++; if (cycle_vec !== 4'b0000) begin n_err++; $display("FAIL reset_cycle_vec: got %b expected 0000", cycle_vec); end
    n_cmp++; if (report_valid !== 1'b0) begin n_err++; $display("FAIL reset_report_valid: got %b expected 0", report_valid); end
    n_cmp++; if (report_proc !== 2'd0) begin n_err++; $display("FAIL reset_report_proc: got %0d expected 0", report_proc); end
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_directed_cycle();
    int exp_list[3] = '{0, 2, 3};
    do_reset();
    dl_in_vec = 4'b0100;
    settle();
    n_cmp++; if (origin !== 4'b0000) begin n_err++; $display("FAIL dir_idle_origin: got %b expected 0000", origin); end
    next_cycle();
    dl_in_vec = '0;
    settle();
    n_cmp++; if (origin !== 4'b0100) begin n_err++; $display("FAIL dir_origin_pulse: got %b expected 0100", origin); end
    next_cycle();
    token_in_vec = 4'b0001;
    settle();
    n_cmp++; if (origin !== 4'b0000) begin n_err++; $display("FAIL dir_origin_one_cycle: got %b expected 0000", origin); end
    n_cmp++; if (cycle_vec !== 4'b0100) begin n_err++; $display("FAIL dir_cycle_vec_load: got %b expected 0100", cycle_vec); end
    n_cmp++; if (token_clear !== 1'b0) begin n_err++; $display("FAIL dir_tc_t1: got %b expected 0", token_clear); end
    next_cycle();
    token_in_vec = 4'b1000;
    settle();
    n_cmp++; if (token_clear !== 1'b0) begin n_err++; $display("FAIL dir_tc_t2: got %b expected 0", token_clear); end
    next_cycle();
    token_in_vec = 4'b0100;
    settle();
    n_cmp++; if (token_clear !== 1'b1) begin n_err++; $display("FAIL dir_tc_return: got %b expected 1", token_clear); end
    n_cmp++; if (dl_flag !== 1'b0) begin n_err++; $display("FAIL dir_dl_flag_early: got %b expected 0", dl_flag); end
    next_cycle();
    token_in_vec = '0;
    report_ready = 1'b1;
    settle();
    n_cmp++; if (cycle_vec !== 4'b1101) begin n_err++; $display("FAIL dir_cycle_vec: got %b expected 1101", cycle_vec); end
    n_cmp++; if (dl_flag !== 1'b1) begin n_err++; $display("FAIL dir_dl_flag: got %b expected 1", dl_flag); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (report_valid !== 1'b1) begin n_err++; $display("FAIL dir_report_valid[%0d]: got %b expected 1", i, report_valid); end
      n_cmp++; if (report_proc !== 2'(exp_list[i])) begin n_err++; $display("FAIL dir_report_proc[%0d]: got %0d expected %0d", i, report_proc, exp_list[i]); end
      next_cycle();
      settle();
    end
    n_cmp++; if (report_valid !== 1'b0) begin n_err++; $display("FAIL dir_done_valid: got %b expected 0", report_valid); end
    n_cmp++; if (cycle_vec !== 4'b1101) begin n_err++; $display("FAIL dir_done_cycle_vec: got %b expected 1101", cycle_vec); end
    n_cmp++; if (dl_flag !== 1'b1) begin n_err++; $display("FAIL dir_done_dl_flag: got %b expected 1", dl_flag); end
    next_cycle();
    dl_in_vec    = 4'b1111;
    token_in_vec = 4'b1111;
    next_cycle();
    settle();
    n_cmp++; if (origin !== 4'b0000) begin n_err++; $display("FAIL dir_done_origin: got %b expected 0000", origin); end
    n_cmp++; if (token_clear !== 1'b0) begin n_err++; $display("FAIL dir_done_token_clear: got %b expected 0", token_clear); end
    n_cmp++; if (dl_flag !== 1'b1) begin n_err++; $display("FAIL dir_done_sticky: got %b expected 1", dl_flag); end
    next_cycle();
  endtask

  task automatic test_ignore_dl_in();
    int exp_list[3] = '{0, 1, 3};
    do_reset();
    dl_in_vec = 4'b1010;
    next_cycle();
    dl_in_vec = 4'b0001;
    settle();
    n_cmp++; if (origin !== 4'b0010) begin n_err++; $display("FAIL ign_origin: got %b expected 0010", origin); end
    next_cycle();
    token_in_vec = 4'b0001;
    settle();
    n_cmp++; if (token_clear !== 1'b0) begin n_err++; $display("FAIL ign_tc_bit0: got %b expected 0", token_clear); end
    next_cycle();
    dl_in_vec    = 4'b1111;
    token_in_vec = 4'b1000;
    settle();
    n_cmp++; if (token_clear !== 1'b0) begin n_err++; $display("FAIL ign_tc_bit3: got %b expected 0", token_clear); end
    next_cycle();
    token_in_vec = 4'b0010;
    settle();
    n_cmp++; if (token_clear !== 1'b1) begin n_err++; $display("FAIL ign_tc_return: got %b expected 1", token_clear); end
    next_cycle();
    token_in_vec = '0;
    dl_in_vec    = '0;
    report_ready = 1'b1;
    settle();
    n_cmp++; if (cycle_vec !== 4'b1011) begin n_err++; $display("FAIL ign_cycle_vec: got %b expected 1011", cycle_vec); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (report_proc !== 2'(exp_list[i])) begin n_err++; $display("FAIL ign_report_proc[%0d]: got %0d expected %0d", i, report_proc, exp_list[i]); end
      next_cycle();
      settle();
    end
    n_cmp++; if (report_valid !== 1'b0) begin n_err++; $display("FAIL ign_done_valid: got %b expected 0", report_valid); end
    next_cycle();
  endtask

  task automatic test_stall();
    do_reset();
    dl_in_vec = 4'b0001;
    next_cycle();
    dl_in_vec = '0;
    next_cycle();
    token_in_vec = 4'b0011;
    settle();
    n_cmp++; if (token_clear !== 1'b1) begin n_err++; $display("FAIL stall_tc: got %b expected 1", token_clear); end
    next_cycle();
    token_in_vec = '0;
    report_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      n_cmp++; if (report_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, report_valid); end
      n_cmp++; if (report_proc !== 2'd0) begin n_err++; $display("FAIL stall_proc[%0d]: got %0d expected 0", i, report_proc); end
      next_cycle();
    end
    report_ready = 1'b1;
    settle();
    n_cmp++; if (report_proc !== 2'd0) begin n_err++; $display("FAIL stall_release_proc: got %0d expected 0", report_proc); end
    next_cycle();
    settle();
    n_cmp++; if (report_proc !== 2'd1) begin n_err++; $display("FAIL stall_next_proc: got %0d expected 1", report_proc); end
    n_cmp++; if (report_valid !== 1'b1) begin n_err++; $display("FAIL stall_next_valid: got %b expected 1", report_valid); end
    next_cycle();
    settle();
    n_cmp++; if (report_valid !== 1'b0) begin n_err++; $display("FAIL stall_done_valid: got %b expected 0", report_valid); end
    next_cycle();
  endtask

  task automatic test_timeout();
    do_reset();
    dl_in_vec = 4'b0100;
    next_cycle();
    dl_in_vec = '0;
    next_cycle();
`ifdef PACKET_HANDLER_DL_TIMEOUT_EN
    for (int t = 1; t <= 8; t++) begin
      token_in_vec = 4'($urandom) & 4'b1011;
      settle();
      n_cmp++; if (token_clear !== (t == 8)) begin n_err++; $display("FAIL tmo_tc[%0d]: got %b expected %b", t, token_clear, (t == 8)); end
      next_cycle();
    end
    token_in_vec = '0;
    settle();
    n_cmp++; if (token_clear !== 1'b0) begin n_err++; $display("FAIL tmo_tc_after: got %b expected 0", token_clear); end
    n_cmp++; if (cycle_vec !== 4'b0000) begin n_err++; $display("FAIL tmo_cycle_vec: got %b expected 0000", cycle_vec); end
    n_cmp++; if (dl_flag !== 1'b0) begin n_err++; $display("FAIL tmo_dl_flag: got %b expected 0", dl_flag); end
    n_cmp++; if (report_valid !== 1'b0) begin n_err++; $display("FAIL tmo_report_valid: got %b expected 0", report_valid); end
    dl_in_vec = 4'b0001;
    next_cycle();
    dl_in_vec = '0;
    settle();
    n_cmp++; if (origin !== 4'b0001) begin n_err++; $display("FAIL tmo_back_to_idle: got %b expected 0001", origin); end
    next_cycle();
`else
    for (int t = 1; t <= 100; t++) begin
      token_in_vec = 4'($urandom) & 4'b1011;
      settle();
      n_cmp++; if (token_clear !== 1'b0) begin n_err++; $display("FAIL notmo_tc[%0d]: got %b expected 0", t, token_clear); end
      next_cycle();
    end
    token_in_vec = '0;
    settle();
    n_cmp++; if (report_valid !== 1'b0) begin n_err++; $display("FAIL notmo_report_valid: got %b expected 0", report_valid); end
    n_cmp++; if (cycle_vec[2] !== 1'b1) begin n_err++; $display("FAIL notmo_cycle_vec_origin: got %b expected 1", cycle_vec[2]); end
    next_cycle();
    token_in_vec = 4'b0100;
    settle();
    n_cmp++; if (token_clear !== 1'b1) begin n_err++; $display("FAIL notmo_still_trace: got %b expected 1", token_clear); end
    next_cycle();
    token_in_vec = '0;
`endif
  endtask

  task automatic test_random_cycles();
    for (int it = 0; it < 30; it++) begin
      logic [3:0] req, oh, tok, exp_set;
      int         exp_idx, k, budget;
      int         q[$];
      do_reset();
      req          = 4'($urandom_range(1, 15));
      exp_idx      = lowest_idx(req);
      oh           = 4'(1 << exp_idx);
      dl_in_vec    = req;
      token_in_vec = 4'($urandom);
      settle();
      n_cmp++; if (token_clear !== 1'b0) begin n_err++; $display("FAIL rnd_idle_tc[%0d]: got %b expected 0", it, token_clear); end
      next_cycle();
      dl_in_vec    = 4'($urandom);
      token_in_vec = 4'($urandom);
      settle();
      n_cmp++; if (origin !== oh) begin n_err++; $display("FAIL rnd_origin[%0d]: got %b expected %b", it, origin, oh); end
      n_cmp++; if (token_clear !== 1'b0) begin n_err++; $display("FAIL rnd_origin_tc[%0d]: got %b expected 0", it, token_clear); end
      next_cycle();
      exp_set = oh;
      k = $urandom_range(0, 7);
      for (int t = 0; t < k; t++) begin
        tok          = 4'($urandom) & ~oh;
        token_in_vec = tok;
        dl_in_vec    = 4'($urandom);
        exp_set      = exp_set | tok;
        settle();
        n_cmp++; if (token_clear !== 1'b0) begin n_err++; $display("FAIL rnd_trace_tc[%0d.%0d]: got %b expected 0", it, t, token_clear); end
        next_cycle();
      end
      tok          = 4'($urandom) | oh;
      token_in_vec = tok;
      exp_set      = exp_set | tok;
      settle();
      n_cmp++; if (token_clear !== 1'b1) begin n_err++; $display("FAIL rnd_return_tc[%0d]: got %b expected 1", it, token_clear); end
      next_cycle();
      token_in_vec = '0;
      for (int i = 0; i < 4; i++) if (exp_set[i]) q.push_back(i);
      settle();
      n_cmp++; if (cycle_vec !== exp_set) begin n_err++; $display("FAIL rnd_cycle_vec[%0d]: got %b expected %b", it, cycle_vec, exp_set); end
      n_cmp++; if (dl_flag !== 1'b1) begin n_err++; $display("FAIL rnd_dl_flag[%0d]: got %b expected 1", it, dl_flag); end
      budget = 64;
      while (q.size() > 0 && budget > 0) begin
        report_ready = 1'($urandom_range(0, 1));
        dl_in_vec    = 4'($urandom);
        settle();
        n_cmp++; if (report_valid !== 1'b1) begin n_err++; $display("FAIL rnd_report_valid[%0d]: got %b expected 1", it, report_valid); end
        n_cmp++; if (report_proc !== 2'(q[0])) begin n_err++; $display("FAIL rnd_report_proc[%0d]: got %0d expected %0d", it, report_proc, q[0]); end
        if (report_ready) void'(q.pop_front());
        budget--;
        next_cycle();
      end
      n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL rnd_report_budget[%0d]: got %0d left expected 0", it, q.size()); end
      report_ready = 1'b0;
      settle();
      n_cmp++; if (report_valid !== 1'b0) begin n_err++; $display("FAIL rnd_done_valid[%0d]: got %b expected 0", it, report_valid); end
      n_cmp++; if (cycle_vec !== exp_set) begin n_err++; $display("FAIL rnd_done_cycle_vec[%0d]: got %b expected %b", it, cycle_vec, exp_set); end
      next_cycle();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    dl_in_vec = 4'b0010;
    next_cycle();
    dl_in_vec = '0;
    next_cycle();
    token_in_vec = 4'b0001;
    next_cycle();
    token_in_vec = '0;
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (cycle_vec !== 4'b0000) begin n_err++; $display("FAIL arst_trace_cycle_vec: got %b expected 0000", cycle_vec); end
    n_cmp++; if (origin !== 4'b0000) begin n_err++; $display("FAIL arst_trace_origin: got %b expected 0000", origin); end
    n_cmp++; if (token_clear !== 1'b0) begin n_err++; $display("FAIL arst_trace_tc: got %b expected 0", token_clear); end
    next_cycle();
    reset     = 1'b0;
    dl_in_vec = 4'b1000;
    settle();
    n_cmp++; if (origin !== 4'b0000) begin n_err++; $display("FAIL arst_idle_origin: got %b expected 0000", origin); end
    next_cycle();
    dl_in_vec = '0;
    settle();
    n_cmp++; if (origin !== 4'b1000) begin n_err++; $display("FAIL arst_restart_origin: got %b expected 1000", origin); end
    next_cycle();
    token_in_vec = 4'b1001;
    next_cycle();
    token_in_vec = '0;
    report_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (report_valid !== 1'b0) begin n_err++; $display("FAIL arst_report_valid: got %b expected 0", report_valid); end
    n_cmp++; if (dl_flag !== 1'b0) begin n_err++; $display("FAIL arst_report_dl_flag: got %b expected 0", dl_flag); end
    n_cmp++; if (report_proc !== 2'd0) begin n_err++; $display("FAIL arst_report_proc: got %0d expected 0", report_proc); end
    n_cmp++; if (cycle_vec !== 4'b0000) begin n_err++; $display("FAIL arst_report_cycle_vec: got %b expected 0000", cycle_vec); end
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    dl_in_vec    = '0;
    token_in_vec = '0;
    report_ready = 1'b0;
    #1;
    test_reset();
    test_directed_cycle();
    test_ignore_dl_in();
    test_stall();
    test_timeout();
    test_random_cycles();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/packet_handler_hls_deadlock_report_unit.md
PACKET_HANDLER_HLS_DEADLOCK_REPORT_UNIT -- requirements
Module: packet_handler_hls_deadlock_report_unit

Interface
REQ-001 SHALL have parameter PROC_NUM, default 4, the number of monitored processes.
REQ-002 SHALL have parameter IDX_W, default 2, the width of a process index; IDX_W >= clog2(PROC_NUM).
REQ-003 SHALL have parameter TIMEOUT, default 64, the maximum number of TRACE cycles to wait for the token to return to the origin.
REQ-004 SHALL have a single clock: clock  input  1  rising-edge clock.
REQ-005 SHALL have reset: reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port dl_in_vec  input  PROC_NUM  per-process deadlock-detect flags from the detect units.
REQ-007 SHALL have port token_in_vec  input  PROC_NUM  per-process token-arrival flags.
REQ-008 SHALL have port origin  output  PROC_NUM  one-hot token-origin select.
REQ-009 SHALL have port token_clear  output  1  pulse that terminates token propagation.
REQ-010 SHALL have port dl_flag  output  1  sticky flag: deadlock confirmed.
REQ-011 SHALL have port cycle_vec  output  PROC_NUM  set of processes in the dependency cycle.
REQ-012 SHALL have port report_valid  output  1  report entry valid.
REQ-013 SHALL have port report_proc  output  IDX_W  index of the reported process.
REQ-014 SHALL have port report_ready  input  1  report consumer ready.

Function
REQ-015 The FSM SHALL have five states: IDLE, ORIGIN, TRACE, REPORT and DONE, one-hot or encoded.
REQ-016 In IDLE, if |dl_in_vec, the block SHALL latch idx = lowest set bit of dl_in_vec and move to ORIGIN.
- Simultaneous requests resolve to the lowest index.
REQ-017 In ORIGIN, origin SHALL equal onehot(idx) for exactly one cycle; cycle_vec SHALL load onehot(idx); the timeout counter SHALL clear; the next state SHALL be TRACE.
REQ-018 In TRACE, each cycle SHALL update cycle_vec <= cycle_vec | token_in_vec.
REQ-019 In TRACE with token_in_vec[idx]=1, token_clear SHALL be 1 combinationally in that same cycle, and the next state SHALL be REPORT.
REQ-020 In REPORT, report_valid SHALL be 1 and report_proc SHALL be the lowest set bit of the pending copy of cycle_vec.
- On report_valid & report_ready, that bit SHALL clear.
- Acceptance of the final bit SHALL move the FSM to DONE; with report_ready held high, one entry is emitted per cycle.
REQ-021 report_proc SHALL hold stable while report_valid=1 and report_ready=0.
REQ-022 dl_flag SHALL be registered, SHALL set on entry to REPORT, and SHALL remain 1 in DONE until reset.
REQ-023 cycle_vec SHALL hold the full cycle set through REPORT and DONE; it is not the pending copy.
REQ-024 dl_in_vec SHALL be ignored in all states except IDLE.
REQ-025 token_in_vec SHALL be ignored in all states except TRACE.
REQ-026 origin, report_valid and token_clear SHALL be 0 whenever the FSM is outside the states that drive them.

Reset
REQ-027 Asserting reset SHALL asynchronously force the FSM to IDLE, including mid-TRACE or mid-REPORT.
REQ-028 Reset values SHALL be:
- origin=0, token_clear=0, dl_flag=0, cycle_vec=0, report_valid=0, report_proc=0;
- idx, the pending vector and the timeout counter cleared.
REQ-029 The first state decision after reset deasserts SHALL occur on the following rising clock edge.

Configuration
REQ-030 With macro PACKET_HANDLER_DL_TIMEOUT_EN defined, a counter SHALL increment on every TRACE cycle.
- When it reaches TIMEOUT-1 with no token_in_vec[idx], token_clear SHALL pulse for one cycle.
- In that case cycle_vec SHALL clear, dl_flag SHALL stay 0, and the FSM SHALL return to IDLE.
- If a token return and the timeout occur in the same cycle, the token return wins.
REQ-031 Without PACKET_HANDLER_DL_TIMEOUT_EN, no counter SHALL exist, TIMEOUT SHALL be unused, and TRACE SHALL wait indefinitely.

Verification (PROC_NUM=4, IDX_W=2)
REQ-032 IDLE, dl_in_vec=4'b0100 for 1 cycle -> origin=4'b0100 for exactly one cycle, cycle_vec=4'b0100, FSM in TRACE.
REQ-033 In TRACE, token_in_vec=0001, then 1000, then 0100 -> token_clear=1 in the 0100 cycle, cycle_vec=4'b1101, dl_flag=1.
- Then, with report_ready=1, report_proc=0, 2, 3 on consecutive cycles, then DONE with report_valid=0.
REQ-034 dl_in_vec=4'b1010 in IDLE -> origin=4'b0010; later dl_in_vec activity during TRACE does not change idx.
REQ-035 Macro defined, TIMEOUT=8, no token return -> token_clear pulses on the 8th TRACE cycle, FSM returns to IDLE, cycle_vec=0, dl_flag=0.
- Macro undefined -> still in TRACE after 100 cycles.
REQ-036 In REPORT, report_ready=0 for 5 cycles -> report_valid stays 1 and report_proc stays 0; report_ready=1 -> advances to the next index.
REQ-037 reset asserted mid-TRACE -> all outputs 0 immediately without a clock edge; after release, a fresh dl_in_vec restarts at ORIGIN.
